// File: rtl/overlay_box_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_box_scheduler_pkg
//  Brief    : Shared types and project constants for the box-overlay path.
//  Revision : 1.0 - initial release
// ============================================================================
package overlay_box_scheduler_pkg;

    // Active picture size of the HDMI output the overlay is drawn on
    localparam int c_img_width    = 1280;
    localparam int c_img_height   = 720;

    // Frames without a fresh tracker result before the shown box is withdrawn
    localparam int c_stale_frames = 8;

    // Overlay stage drawing constants (line thickness in pixels, RGB colour)
    localparam int              c_box_line_px = 2;
    localparam logic [23:0]     c_box_rgb     = 24'h00FF00;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // nothing shown, nothing pending
        ARMED     = 2'd1,   // result pending, nothing shown yet
        SHOW      = 2'd2,   // box shown, nothing pending
        SHOW_PEND = 2'd3    // box shown, newer result waiting for next frame
    } state_t;

endpackage : overlay_box_scheduler_pkg
`default_nettype wire

// File: rtl/overlay_box_scheduler_box_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_box_scheduler_box_clamp
//  Brief    : Combinational validate/clamp of one tracker box to image bounds.
//  Revision : 1.0 - initial release
// ============================================================================
module overlay_box_scheduler_box_clamp
    import overlay_box_scheduler_pkg::*;
#(
    parameter int IMG_WIDTH  = c_img_width,
    parameter int IMG_HEIGHT = c_img_height
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] w,
    input  logic [15:0] h,
    output logic [15:0] clamp_x,
    output logic [15:0] clamp_y,
    output logic [15:0] clamp_w,
    output logic [15:0] clamp_h,
    output logic        invalid
);

    localparam logic [15:0] c_w16      = 16'(IMG_WIDTH);
    localparam logic [15:0] c_h16      = 16'(IMG_HEIGHT);
    localparam logic [15:0] c_w_last16 = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] c_h_last16 = 16'(IMG_HEIGHT - 1);
    localparam logic [16:0] c_w_last17 = 17'(IMG_WIDTH - 1);
    localparam logic [16:0] c_h_last17 = 17'(IMG_HEIGHT - 1);

    // Far edges in 17 bits so a huge width/height cannot wrap past the bound
    logic [16:0] w_x_end;
    logic [16:0] w_y_end;

    assign w_x_end = {1'b0, x} + {1'b0, w};
    assign w_y_end = {1'b0, y} + {1'b0, h};

    // Validate the box and trim its extent to the last visible pixel
    always_comb begin
        clamp_x = x;
        clamp_y = y;
        clamp_w = (w_x_end > c_w_last17) ? (c_w_last16 - x) : w;
        clamp_h = (w_y_end > c_h_last17) ? (c_h_last16 - y) : h;
        invalid = (w == 16'd0) || (h == 16'd0) || (x >= c_w16) || (y >= c_h16);
    end

endmodule : overlay_box_scheduler_box_clamp
`default_nettype wire

// File: rtl/overlay_box_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_box_scheduler
//  Brief    : Takes tracker boxes, clamps them and commits them to the HDMI
//             overlay only at frame boundaries; withdraws stale boxes.
//  Revision : 1.0 - initial release
// ============================================================================
module overlay_box_scheduler
    import overlay_box_scheduler_pkg::*;
#(
    parameter int IMG_WIDTH    = c_img_width,
    parameter int IMG_HEIGHT   = c_img_height,
    parameter int STALE_FRAMES = c_stale_frames
) (
    input  logic        hdmi_pclk,
    input  logic        s_rst_n,
    input  logic        hdmi_vs,
    input  logic        overlay_en,
    input  logic        trk_valid,
    output logic        trk_ready,
    input  logic [15:0] trk_x,
    input  logic [15:0] trk_y,
    input  logic [15:0] trk_w,
    input  logic [15:0] trk_h,
    output logic [15:0] result_x,
    output logic [15:0] result_y,
    output logic [15:0] result_w,
    output logic [15:0] result_h,
    output logic        hdmi_vs_sel,
    output logic        box_stale,
    output logic        reject,
    output logic [7:0]  drop_cnt,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] c_stale_last = 8'(STALE_FRAMES - 1);

    state_t      r_state, w_state_nxt;
    logic        r_vs_d, r_ready, r_sel, r_box_stale, r_reject;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt, r_stale_cnt;
    logic [15:0] r_pend_x, r_pend_y, r_pend_w, r_pend_h;
    logic [15:0] r_res_x, r_res_y, r_res_w, r_res_h;

    logic        w_vs_rise, w_xfer, w_acc, w_invalid;
    logic [15:0] w_cx, w_cy, w_cw, w_ch;
    logic        w_commit, w_pend_ld, w_drop, w_stale_clr, w_stale_inc, w_stale_hit;

    assign w_vs_rise = hdmi_vs & ~r_vs_d;
    assign w_xfer    = trk_valid & r_ready;
    assign w_acc     = w_xfer & ~w_invalid;

    overlay_box_scheduler_box_clamp #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_box_clamp (
        .x       (trk_x),
        .y       (trk_y),
        .w       (trk_w),
        .h       (trk_h),
        .clamp_x (w_cx),
        .clamp_y (w_cy),
        .clamp_w (w_cw),
        .clamp_h (w_ch),
        .invalid (w_invalid)
    );

    // Frame edge detect and free-running frame counter
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_vs_d      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_vs_d <= hdmi_vs;
            if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Ready follows the enable one cycle late
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) r_ready <= 1'b0;
        else          r_ready <= overlay_en;
    end

    // State register
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and per-cycle actions; a vs_rise commits the old pending
    // before a same-cycle transfer refills it, so that case is never a drop
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_pend_ld   = 1'b0;
        w_drop      = 1'b0;
        w_stale_clr = 1'b0;
        w_stale_inc = 1'b0;
        w_stale_hit = 1'b0;
        if (!overlay_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        w_pend_ld   = 1'b1;
                        w_state_nxt = ARMED;
                    end
                end
                ARMED, SHOW_PEND: begin
                    w_pend_ld = w_acc;
                    if (w_vs_rise) begin
                        w_commit    = 1'b1;
                        w_stale_clr = 1'b1;
                        w_state_nxt = w_acc ? SHOW_PEND : SHOW;
                    end else begin
                        w_drop = w_acc;
                    end
                end
                SHOW: begin
                    if (w_acc) begin
                        w_pend_ld   = 1'b1;
                        w_stale_clr = w_vs_rise;
                        w_state_nxt = SHOW_PEND;
                    end else if (w_vs_rise) begin
                        if (r_stale_cnt == c_stale_last) begin
                            w_stale_hit = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_stale_inc = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Pending result holds the clamped box until the next frame boundary
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_pend_x <= 16'd0;
            r_pend_y <= 16'd0;
            r_pend_w <= 16'd0;
            r_pend_h <= 16'd0;
        end else if (w_pend_ld) begin
            r_pend_x <= w_cx;
            r_pend_y <= w_cy;
            r_pend_w <= w_cw;
            r_pend_h <= w_ch;
        end
    end

    // Committed box and draw enable; only move on a frame boundary
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_res_x <= 16'd0;
            r_res_y <= 16'd0;
            r_res_w <= 16'd0;
            r_res_h <= 16'd0;
            r_sel   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_res_x <= r_pend_x;
                r_res_y <= r_pend_y;
                r_res_w <= r_pend_w;
                r_res_h <= r_pend_h;
            end
            r_sel <= (w_state_nxt == SHOW) || (w_state_nxt == SHOW_PEND);
        end
    end

    // Frames since the shown box was committed
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n)         r_stale_cnt <= 8'd0;
        else if (w_stale_clr) r_stale_cnt <= 8'd0;
        else if (w_stale_inc) r_stale_cnt <= r_stale_cnt + 8'd1;
    end

    // Status pulses and saturating drop counter
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_box_stale <= 1'b0;
            r_reject    <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_box_stale <= w_stale_hit;
            r_reject    <= w_xfer & w_invalid;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign trk_ready   = r_ready;
    assign result_x    = r_res_x;
    assign result_y    = r_res_y;
    assign result_w    = r_res_w;
    assign result_h    = r_res_h;
    assign hdmi_vs_sel = r_sel;
    assign box_stale   = r_box_stale;
    assign reject      = r_reject;
    assign drop_cnt    = r_drop_cnt;
    assign frame_cnt   = r_frame_cnt;

endmodule : overlay_box_scheduler
`default_nettype wire

// File: tb/tb_overlay_box_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_overlay_box_scheduler
//  Brief    : Directed and random stimulus for overlay_box_scheduler against
//             an event-level reference model of the scheduling rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_overlay_box_scheduler;

    localparam int IMG_WIDTH    = 1280;
    localparam int IMG_HEIGHT   = 720;
    localparam int STALE_FRAMES = 8;

    logic        hdmi_pclk = 1'b0;
    logic        s_rst_n, hdmi_vs, overlay_en, trk_valid, trk_ready;
    logic [15:0] trk_x, trk_y, trk_w, trk_h;
    logic [15:0] result_x, result_y, result_w, result_h;
    logic        hdmi_vs_sel, box_stale, reject;
    logic [7:0]  drop_cnt;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int stale_seen;

    overlay_box_scheduler #(
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT),
        .STALE_FRAMES (STALE_FRAMES)
    ) dut (
        .hdmi_pclk   (hdmi_pclk),
        .s_rst_n     (s_rst_n),
        .hdmi_vs     (hdmi_vs),
        .overlay_en  (overlay_en),
        .trk_valid   (trk_valid),
        .trk_ready   (trk_ready),
        .trk_x       (trk_x),
        .trk_y       (trk_y),
        .trk_w       (trk_w),
        .trk_h       (trk_h),
        .result_x    (result_x),
        .result_y    (result_y),
        .result_w    (result_w),
        .result_h    (result_h),
        .hdmi_vs_sel (hdmi_vs_sel),
        .box_stale   (box_stale),
        .reject      (reject),
        .drop_cnt    (drop_cnt),
        .frame_cnt   (frame_cnt)
    );

    always #5 hdmi_pclk = ~hdmi_pclk;

    // ---------------- reference model (event level) ----------------
    bit m_ready, m_vs_d, m_have_pend, m_shown, m_reject, m_stale_pulse;
    int m_age, m_drop, m_frame;
    int m_pend[4];
    int m_res[4];

    function automatic int clampv(int p, int s, int lim);
        return (p + s > lim - 1) ? (lim - 1 - p) : s;
    endfunction

    task automatic model_reset();
        m_ready = 0; m_vs_d = 0; m_have_pend = 0; m_shown = 0;
        m_reject = 0; m_stale_pulse = 0; m_age = 0; m_drop = 0; m_frame = 0;
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_res[i] = 0; end
    endtask

    // Apply one clock edge: commit on frame start first, then take the new result
    task automatic model_update();
        bit xfer, vr, bad, acc;
        if (!s_rst_n) begin model_reset(); return; end
        xfer = trk_valid && m_ready;
        vr   = hdmi_vs && !m_vs_d;
        bad  = (trk_w == 0) || (trk_h == 0) || (int'(trk_x) >= IMG_WIDTH) || (int'(trk_y) >= IMG_HEIGHT);
        acc  = xfer && !bad;
        m_reject = xfer && bad;
        m_stale_pulse = 0;
        if (vr) m_frame = (m_frame + 1) % 65536;
        if (!overlay_en) begin
            m_have_pend = 0;
            m_shown     = 0;
        end else begin
            if (vr && m_have_pend) begin
                m_res = m_pend;
                m_have_pend = 0;
                m_shown = 1;
                m_age = 0;
            end else if (vr && m_shown) begin
                if (acc) m_age = 0;
                else begin
                    m_age++;
                    if (m_age >= STALE_FRAMES) begin m_shown = 0; m_stale_pulse = 1; end
                end
            end
            if (acc) begin
                if (m_have_pend && m_drop < 255) m_drop++;
                m_pend[0] = trk_x;
                m_pend[1] = trk_y;
                m_pend[2] = clampv(trk_x, trk_w, IMG_WIDTH);
                m_pend[3] = clampv(trk_y, trk_h, IMG_HEIGHT);
                m_have_pend = 1;
            end
        end
        m_ready = overlay_en;
        m_vs_d  = hdmi_vs;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("trk_ready",   32'(trk_ready),   32'(m_ready));
        chk("result_x",    32'(result_x),    32'(m_res[0]));
        chk("result_y",    32'(result_y),    32'(m_res[1]));
        chk("result_w",    32'(result_w),    32'(m_res[2]));
        chk("result_h",    32'(result_h),    32'(m_res[3]));
        chk("hdmi_vs_sel", 32'(hdmi_vs_sel), 32'(m_shown));
        chk("box_stale",   32'(box_stale),   32'(m_stale_pulse));
        chk("reject",      32'(reject),      32'(m_reject));
        chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
        chk("frame_cnt",   32'(frame_cnt),   32'(m_frame));
        if (box_stale === 1'b1) stale_seen++;
    endtask

    task automatic tick();
        @(posedge hdmi_pclk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic vs_pulse();
        hdmi_vs = 1'b1; tick();
        hdmi_vs = 1'b0; tick();
    endtask

    task automatic set_box(input int x, input int y, input int w, input int h);
        trk_x = 16'(x); trk_y = 16'(y); trk_w = 16'(w); trk_h = 16'(h);
    endtask

    task automatic send(input int x, input int y, input int w, input int h);
        set_box(x, y, w, h);
        trk_valid = 1'b1; tick();
        trk_valid = 1'b0; tick();
    endtask

    task automatic chk_box(input string tag, input int x, input int y, input int w, input int h);
        chk({tag, "_x"}, 32'(result_x), 32'(x));
        chk({tag, "_y"}, 32'(result_y), 32'(y));
        chk({tag, "_w"}, 32'(result_w), 32'(w));
        chk({tag, "_h"}, 32'(result_h), 32'(h));
    endtask

    function automatic int rnd_ext();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return int'($urandom_range(0, 65535));
        return int'($urandom_range(1, 200));
    endfunction

    initial begin
        s_rst_n = 1'b0; hdmi_vs = 1'b0; overlay_en = 1'b0; trk_valid = 1'b0;
        set_box(0, 0, 0, 0);
        stale_seen = 0;
        model_reset();

        // Reset state, ready held low under reset
        overlay_en = 1'b1;
        repeat (3) tick();
        s_rst_n = 1'b1;
        repeat (2) tick();
        chk("reset_ready_up", 32'(trk_ready), 32'd1);

        // Basic commit: nothing changes until the next frame boundary
        vs_pulse();
        send(100, 50, 40, 30);
        repeat (3) tick();
        chk("basic_pre_sel", 32'(hdmi_vs_sel), 32'd0);
        hdmi_vs = 1'b1; tick();
        chk_box("basic", 100, 50, 40, 30);
        chk("basic_sel", 32'(hdmi_vs_sel), 32'd1);
        hdmi_vs = 1'b0; tick();

        // Clamp at bottom-right corner
        send(1260, 700, 100, 100);
        vs_pulse();
        chk_box("clamp", 1260, 700, 19, 19);

        // Reject: zero width
        set_box(10, 10, 0, 5);
        trk_valid = 1'b1; tick();
        chk("reject_pulse", 32'(reject), 32'd1);
        trk_valid = 1'b0; tick();
        chk("reject_clear", 32'(reject), 32'd0);
        chk("reject_keep_sel", 32'(hdmi_vs_sel), 32'd1);

        // Three results in one frame: last one wins, two drops
        send(200, 100, 10, 10);
        send(300, 200, 20, 20);
        send(400, 300, 30, 30);
        chk("drop_two", 32'(drop_cnt), 32'd2);
        vs_pulse();
        chk_box("drop_last", 400, 300, 30, 30);

        // Staleness: withdrawn at the 8th frame edge after commit
        stale_seen = 0;
        for (int i = 0; i < STALE_FRAMES; i++) begin
            hdmi_vs = 1'b1; tick();
            chk("stale_sel", 32'(hdmi_vs_sel), (i < STALE_FRAMES - 1) ? 32'd1 : 32'd0);
            hdmi_vs = 1'b0; tick();
        end
        repeat (3) tick();
        chk("stale_pulses", 32'(stale_seen), 32'd1);
        chk_box("stale_hold", 400, 300, 30, 30);

        // Collision: B transferred on the frame edge that commits A
        send(50, 60, 70, 80);
        set_box(500, 400, 60, 50);
        hdmi_vs = 1'b1; trk_valid = 1'b1; tick();
        chk_box("coll_a", 50, 60, 70, 80);
        chk("coll_sel", 32'(hdmi_vs_sel), 32'd1);
        hdmi_vs = 1'b0; trk_valid = 1'b0; tick();
        vs_pulse();
        chk_box("coll_b", 500, 400, 60, 50);
        chk("coll_drop", 32'(drop_cnt), 32'd2);

        // Disable while showing
        overlay_en = 1'b0; tick();
        chk("dis_sel", 32'(hdmi_vs_sel), 32'd0);
        chk("dis_ready", 32'(trk_ready), 32'd0);
        chk_box("dis_hold", 500, 400, 60, 50);
        overlay_en = 1'b1; repeat (2) tick();

        // Reset mid-frame: everything clears at once
        send(123, 45, 67, 89);
        vs_pulse();
        tick();
        s_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk_box("rst_async", 0, 0, 0, 0);
        tick();
        s_rst_n = 1'b1;
        repeat (2) tick();
        vs_pulse();
        chk("rst_no_draw", 32'(hdmi_vs_sel), 32'd0);
        send(11, 22, 33, 44);
        chk("rst_wait_vs", 32'(hdmi_vs_sel), 32'd0);
        vs_pulse();
        chk("rst_draw", 32'(hdmi_vs_sel), 32'd1);
        chk_box("rst_box", 11, 22, 33, 44);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            overlay_en = ($urandom_range(0, 99) > 2);
            hdmi_vs    = ($urandom_range(0, 7) == 0);
            trk_valid  = ($urandom_range(0, 9) < 4);
            set_box(int'($urandom_range(0, 1300)), int'($urandom_range(0, 740)), rnd_ext(), rnd_ext());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_overlay_box_scheduler
`default_nettype wire

// File: doc/overlay_box_scheduler.md
Name: overlay_box_scheduler

Overview:
- Sits between the tracker result interface and the HDMI box-overlay stage, all in the hdmi_pclk domain.
- Accepts tracker box results through a valid/ready handshake and holds one pending result.
- Clamps the box to image bounds and commits it to the overlay only at a frame boundary (rising edge of hdmi_vs), so coordinates never change mid-frame.
- Drives hdmi_vs_sel to enable or disable drawing, and retires a box that has gone stale.

Parameters:
- IMG_WIDTH, 1280, active pixels per line.
- IMG_HEIGHT, 720, active lines per frame.
- STALE_FRAMES, 8, frames with no new result before the shown box is withdrawn (1..255).

Ports:
- hdmi_pclk  in  1  pixel clock; the single clock.
- s_rst_n  in  1  reset, asynchronous assert, active-low.
- hdmi_vs  in  1  vertical sync of the video being overlaid, active-high.
- overlay_en  in  1  level; 0 forces the overlay off.
- trk_valid  in  1  tracker result valid.
- trk_ready  out  1  scheduler can take a result.
- trk_x, trk_y, trk_w, trk_h  in  16 each  tracker box: top-left corner, width, height.
- result_x, result_y, result_w, result_h  out  16 each  committed, clamped box to the overlay.
- hdmi_vs_sel  out  1  box drawing enabled for the current frame.
- box_stale  out  1  one-cycle pulse when the box is withdrawn for staleness.
- reject  out  1  one-cycle pulse when an accepted result is discarded as invalid.
- drop_cnt  out  8  saturating count of pending results overwritten before commit.
- frame_cnt  out  16  free-running count of vs rising edges; wraps.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; pending empty; stale counter 0; vs_d 0.
  - trk_ready stays 0 while reset is asserted.
- Reset mid-frame clears everything immediately. After reset, nothing is drawn until a result is accepted and a vs edge has occurred.
- VS edge:
  - vs_d is hdmi_vs registered.
  - vs_rise = hdmi_vs & ~vs_d (combinational).
  - frame_cnt increments on every cycle with vs_rise.
- Handshake:
  - trk_ready = overlay_en (registered, one-cycle lag).
  - A transfer happens on a cycle with trk_valid & trk_ready.
  - Latest result wins: a transfer while pending is full overwrites pending and increments drop_cnt (saturates at 255).
- Validation and clamp, applied at transfer, before the result is stored:
  - Reject when w==0, h==0, x>=IMG_WIDTH or y>=IMG_HEIGHT. reject pulses the next cycle, pending is unchanged, and the transfer is not counted as a drop.
  - Otherwise store x and y unchanged.
  - w' = min(w, IMG_WIDTH-1-x); h' = min(h, IMG_HEIGHT-1-y).
  - Sums are computed in 17 bits so that x+w cannot wrap.
- States:
  - IDLE: nothing shown, pending empty. A valid transfer goes to ARMED.
  - ARMED: pending full, nothing shown. On vs_rise, load result_* from pending, clear pending, clear the stale counter and go to SHOW.
  - SHOW: box shown, pending empty.
    - A valid transfer goes to SHOW_PEND.
    - A vs_rise increments the stale counter.
    - When the counter reaches STALE_FRAMES at a vs_rise, go to IDLE and pulse box_stale. result_* hold their last values.
  - SHOW_PEND: on vs_rise, load result_* from pending, clear pending, clear the stale counter and go to SHOW.
- Output timing:
  - hdmi_vs_sel is registered: 1 in SHOW/SHOW_PEND, 0 otherwise.
  - result_* and hdmi_vs_sel change on the clock edge at which vs_rise is sampled, and on no other edge. The only exceptions are overlay_en and reset.
  - Latency from vs_rise to the new box at the outputs is 1 clock.
- Simultaneous transfer and vs_rise (ARMED or SHOW_PEND): the old pending is committed and the new result becomes pending. The state is SHOW_PEND, not SHOW. It is not a drop.
- Simultaneous transfer and vs_rise in SHOW: the stale counter clears, the state becomes SHOW_PEND, and the new box waits for the next vs_rise.
- overlay_en falling:
  - Next cycle: state IDLE, pending cleared, hdmi_vs_sel 0.
  - result_* hold; drop_cnt holds; frame_cnt keeps counting.

Decomposition:
- Shared package: the state enum (IDLE, ARMED, SHOW, SHOW_PEND), and IMG_WIDTH/IMG_HEIGHT defaults as project constants alongside the overlay stage's values.
- One natural sub-module, box_clamp: purely combinational validate/clamp of x, y, w, h producing the clamped box plus an invalid flag. It is reused if the overlay later takes multiple boxes.

Test Plan:
- Basic commit: trk (100,50,40,30) mid-frame -> no output change until vs rises; one clock after vs_rise, result=(100,50,40,30) and hdmi_vs_sel=1.
- Clamp: trk (1260,700,100,100) -> committed result (1260,700,19,19).
- Reject and drop:
  - trk w=0 -> reject pulse, state unchanged.
  - Three valid results within one frame -> the last one is committed and drop_cnt=2.
- Staleness: STALE_FRAMES=8, one result then none -> hdmi_vs_sel falls at the 8th vs_rise after commit and box_stale pulses once.
- Collision: ARMED with box A; box B transferred on the exact vs_rise cycle -> A is committed, state SHOW_PEND; B is committed at the next vs_rise; drop_cnt unchanged.
- Disable and reset:
  - overlay_en drops in SHOW -> hdmi_vs_sel=0 next cycle and trk_ready=0.
  - s_rst_n pulsed mid-frame -> all outputs 0 immediately, and nothing is drawn until a result has been accepted and a new vs_rise has occurred.
